// File: rtl/vga_sync_gen.sv
// 640x480 VGA timing generator: pixel-tick divider, horizontal/vertical scan
// counters, registered active-low syncs aligned with pixel_x/pixel_y.
module vga_sync_gen #(
  parameter int CLK_DIV = 2,
  parameter int HD      = 640,
  parameter int HF      = 16,
  parameter int HR      = 96,
  parameter int HB      = 48,
  parameter int VD      = 480,
  parameter int VF      = 10,
  parameter int VR      = 2,
  parameter int VB      = 33
) (
  input  logic       clk,
  input  logic       reset,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       p_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       frame_tick
);

  localparam int HT = HD + HF + HR + HB;
  localparam int VT = VD + VF + VR + VB;

  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(HT - 1);
  localparam logic [9:0] V_LAST   = 10'(VT - 1);
  localparam logic [9:0] H_DISP   = 10'(HD);
  localparam logic [9:0] V_DISP   = 10'(VD);
  localparam logic [9:0] HS_FIRST = 10'(HD + HF);
  localparam logic [9:0] HS_LAST  = 10'(HD + HF + HR - 1);
  localparam logic [9:0] VS_FIRST = 10'(VD + VF);
  localparam logic [9:0] VS_LAST  = 10'(VD + VF + VR - 1);

  logic [3:0] div_cnt;
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic [9:0] h_next;
  logic [9:0] v_next;
  logic       h_end;
  logic       v_end;

  assign p_tick = (div_cnt == DIV_LAST);
  // >= rather than == so a forced out-of-range count still wraps on the next tick
  assign h_end  = (h_cnt >= H_LAST);
  assign v_end  = (v_cnt >= V_LAST);

  always_comb begin
    h_next = h_cnt;
    v_next = v_cnt;
    if (p_tick) begin
      h_next = h_end ? 10'd0 : h_cnt + 10'd1;
      if (h_end || (v_cnt > V_LAST))
        v_next = v_end ? 10'd0 : v_cnt + 10'd1;
    end
  end

  // Syncs are registered from the next count so they line up with pixel_x/pixel_y
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= 4'd0;
      h_cnt   <= 10'd0;
      v_cnt   <= 10'd0;
      hsync   <= 1'b1;
      vsync   <= 1'b1;
    end else begin
      div_cnt <= (div_cnt >= DIV_LAST) ? 4'd0 : div_cnt + 4'd1;
      h_cnt   <= h_next;
      v_cnt   <= v_next;
      hsync   <= !((h_next >= HS_FIRST) && (h_next <= HS_LAST));
      vsync   <= !((v_next >= VS_FIRST) && (v_next <= VS_LAST));
    end
  end

  assign pixel_x    = h_cnt;
  assign pixel_y    = v_cnt;
  assign video_on   = (h_cnt < H_DISP) && (v_cnt < V_DISP);
  assign frame_tick = p_tick && (h_cnt == H_LAST) && (v_cnt == V_LAST);

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: default-timing instance for line checks, a shrunken CLK_DIV=1
// instance (16x9 totals) for full-frame, vsync and frame_tick checks.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       a_hsync, a_vsync, a_video_on, a_p_tick, a_frame_tick;
  logic [9:0] a_pixel_x, a_pixel_y;
  logic       b_hsync, b_vsync, b_video_on, b_p_tick, b_frame_tick;
  logic [9:0] b_pixel_x, b_pixel_y;

  vga_sync_gen dut_a (
    .clk(clk), .reset(reset), .hsync(a_hsync), .vsync(a_vsync),
    .video_on(a_video_on), .p_tick(a_p_tick), .pixel_x(a_pixel_x),
    .pixel_y(a_pixel_y), .frame_tick(a_frame_tick)
  );

  // HT=16 (sync low at x 10..12), VT=9 (sync low at y 5..6), 144 clks per frame
  vga_sync_gen #(
    .CLK_DIV(1), .HD(8), .HF(2), .HR(3), .HB(3),
    .VD(4), .VF(1), .VR(2), .VB(2)
  ) dut_b (
    .clk(clk), .reset(reset), .hsync(b_hsync), .vsync(b_vsync),
    .video_on(b_video_on), .p_tick(b_p_tick), .pixel_x(b_pixel_x),
    .pixel_y(b_pixel_y), .frame_tick(b_frame_tick)
  );

  typedef struct {
    int cyc; int px; int py; int hs; int vs; int von; int pt;
  } vec_t;

  vec_t vecs[11];
  int tests = 0;
  int fails = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Holds reset for the given clocks; returns just after the last reset edge
  task automatic applyStimulus(input int hold);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (hold) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    int vi, ticks, hs_low, von_cnt, ft_cnt, ft_cyc, pt_low, vs_low, found;

    // cycle 0 is the first cycle after reset release; x = cyc/2 while CLK_DIV=2
    vecs[0]  = '{0,    0,   0, 1, 1, 1, 0};
    vecs[1]  = '{1,    0,   0, 1, 1, 1, 1};
    vecs[2]  = '{2,    1,   0, 1, 1, 1, 0};
    vecs[3]  = '{1279, 639, 0, 1, 1, 1, 1};
    vecs[4]  = '{1280, 640, 0, 1, 1, 0, 0};
    vecs[5]  = '{1311, 655, 0, 1, 1, 0, 1};
    vecs[6]  = '{1312, 656, 0, 0, 1, 0, 0};
    vecs[7]  = '{1503, 751, 0, 0, 1, 0, 1};
    vecs[8]  = '{1504, 752, 0, 1, 1, 0, 0};
    vecs[9]  = '{1599, 799, 0, 1, 1, 0, 1};
    vecs[10] = '{1600, 0,   1, 1, 1, 1, 0};

    // Line 0 of the default instance
    applyStimulus(5);
    vi = 0; ticks = 0; hs_low = 0; von_cnt = 0; ft_cnt = 0;
    for (int c = 0; c <= 1600; c++) begin
      if (c < 1600) begin
        if (a_p_tick) ticks++;
        if (a_p_tick && !a_hsync) hs_low++;
        if (a_p_tick && a_video_on) von_cnt++;
        if (a_frame_tick) ft_cnt++;
      end
      if (vi < 11 && c == vecs[vi].cyc) begin
        checkOutput($sformatf("vec%0d pixel_x", c), 32'(a_pixel_x), vecs[vi].px);
        checkOutput($sformatf("vec%0d pixel_y", c), 32'(a_pixel_y), vecs[vi].py);
        checkOutput($sformatf("vec%0d hsync", c), 32'(a_hsync), vecs[vi].hs);
        checkOutput($sformatf("vec%0d vsync", c), 32'(a_vsync), vecs[vi].vs);
        checkOutput($sformatf("vec%0d video_on", c), 32'(a_video_on), vecs[vi].von);
        checkOutput($sformatf("vec%0d p_tick", c), 32'(a_p_tick), vecs[vi].pt);
        vi++;
      end
      if (c < 1600) step();
    end
    checkOutput("vectors visited", vi, 11);
    checkOutput("line ticks", ticks, 800);
    checkOutput("line hsync low ticks", hs_low, 96);
    checkOutput("line video_on ticks", von_cnt, 640);
    checkOutput("line0 frame_tick", ft_cnt, 0);

    // Mid-line reset on the default instance at x=700 (inside hsync)
    applyStimulus(1);
    found = 0;
    for (int c = 0; c < 2000 && found == 0; c++) begin
      if (a_pixel_x == 10'd700) found = 1;
      else step();
    end
    checkOutput("reach x700", found, 1);
    checkOutput("x700 hsync", 32'(a_hsync), 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    checkOutput("midreset pixel_x", 32'(a_pixel_x), 0);
    checkOutput("midreset pixel_y", 32'(a_pixel_y), 0);
    checkOutput("midreset hsync", 32'(a_hsync), 1);
    checkOutput("midreset p_tick", 32'(a_p_tick), 0);
    step();
    checkOutput("midreset p_tick+1", 32'(a_p_tick), 1);
    checkOutput("midreset pixel_x+1", 32'(a_pixel_x), 0);
    step();
    checkOutput("midreset pixel_x+2", 32'(a_pixel_x), 1);

    // Full frame on the small CLK_DIV=1 instance
    applyStimulus(2);
    ft_cnt = 0; ft_cyc = -1; pt_low = 0; vs_low = 0; hs_low = 0; von_cnt = 0;
    for (int c = 0; c <= 144; c++) begin
      if (c < 144) begin
        if (!b_p_tick) pt_low++;
        if (b_frame_tick) begin ft_cnt++; ft_cyc = c; end
        if (!b_vsync) vs_low++;
        if (!b_hsync) hs_low++;
        if (b_video_on) von_cnt++;
      end
      if (c == 0) begin
        checkOutput("b reset video_on", 32'(b_video_on), 1);
        checkOutput("b reset vsync", 32'(b_vsync), 1);
      end
      if (c == 79) checkOutput("b y4 vsync", 32'(b_vsync), 1);
      if (c == 80) checkOutput("b y5 vsync", 32'(b_vsync), 0);
      if (c == 111) checkOutput("b y6 vsync", 32'(b_vsync), 0);
      if (c == 112) checkOutput("b y7 vsync", 32'(b_vsync), 1);
      if (c == 143) begin
        checkOutput("b wrap pixel_x", 32'(b_pixel_x), 15);
        checkOutput("b wrap pixel_y", 32'(b_pixel_y), 8);
        checkOutput("b wrap frame_tick", 32'(b_frame_tick), 1);
      end
      if (c == 144) begin
        checkOutput("b after wrap pixel_x", 32'(b_pixel_x), 0);
        checkOutput("b after wrap pixel_y", 32'(b_pixel_y), 0);
        checkOutput("b after wrap frame_tick", 32'(b_frame_tick), 0);
      end
      if (c < 144) step();
    end
    checkOutput("b p_tick low clks", pt_low, 0);
    checkOutput("b frame_tick count", ft_cnt, 1);
    checkOutput("b frame_tick cycle", ft_cyc, 143);
    checkOutput("b vsync low clks", vs_low, 32);
    checkOutput("b hsync low clks", hs_low, 27);
    checkOutput("b video_on clks", von_cnt, 32);

    // Mid-frame reset on the small instance while both syncs are low
    applyStimulus(1);
    found = 0;
    for (int c = 0; c < 300 && found == 0; c++) begin
      if (b_pixel_x == 10'd12 && b_pixel_y == 10'd5) found = 1;
      else step();
    end
    checkOutput("b reach (12,5)", found, 1);
    checkOutput("b (12,5) syncs", 32'({b_hsync, b_vsync}), 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    checkOutput("b midreset pixel_x", 32'(b_pixel_x), 0);
    checkOutput("b midreset pixel_y", 32'(b_pixel_y), 0);
    checkOutput("b midreset syncs", 32'({b_hsync, b_vsync}), 3);
    checkOutput("b midreset p_tick", 32'(b_p_tick), 1);
    repeat (16) step();
    checkOutput("b midreset+16 pixel_y", 32'(b_pixel_y), 1);
    checkOutput("b midreset+16 pixel_x", 32'(b_pixel_x), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
